alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_core.sv | 44 ++++
 rtl/alu_issue_arbiter.sv | 135 +++++++++++++
 tb/tb_alu_issue_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue arbiter: opcode values, FSM state
// encoding, result bundle and the default tag width.
package alu_pkg;

    localparam int TAG_W_DEF = 4;
    localparam int DATA_W    = 32;
    localparam int OP_W      = 5;
    localparam int CNT_W     = 16;

    localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
    localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
    localparam logic [OP_W-1:0] OP_AND = 5'b00010;
    localparam logic [OP_W-1:0] OP_OR  = 5'b00011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              ne;
        logic              lt;
        logic              ovf;
        logic              err;
    } alu_res_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: wrapping add/sub with signed-overflow and compare flags,
// bitwise and/or; unknown opcodes return zero data with the error bit set.
module alu_core
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [OP_W-1:0]   op,
    output alu_res_t          res
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              add_ovf;
    logic              sub_ovf;

    assign sum  = op_a + op_b;
    assign diff = op_a - op_b;

    // Overflow when the operands' signs make the result sign impossible.
    assign add_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1]  != op_a[DATA_W-1]);
    assign sub_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        res = '0;
        case (op)
            OP_ADD: begin
                res.data = sum;
                res.ovf  = add_ovf;
            end
            OP_SUB: begin
                res.data = diff;
                res.ovf  = sub_ovf;
                res.ne   = |(op_a ^ op_b);
                res.lt   = diff[DATA_W-1] ^ sub_ovf;
            end
            OP_AND:  res.data = op_a & op_b;
            OP_OR:   res.data = op_a | op_b;
            default: res.err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a single ALU, with a
// one-entry registered result slot and per-requester acceptance counters.
module alu_issue_arbiter
    import alu_pkg::*;
#(
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [DATA_W-1:0]   req0_opA,
    input  logic [DATA_W-1:0]   req0_opB,
    input  logic [OP_W-1:0]     req0_op,
    input  logic [TAG_W-1:0]    req0_tag,

    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [DATA_W-1:0]   req1_opA,
    input  logic [DATA_W-1:0]   req1_opB,
    input  logic [OP_W-1:0]     req1_op,
    input  logic [TAG_W-1:0]    req1_tag,

    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_data,
    output logic                res_ne,
    output logic                res_lt,
    output logic                res_ovf,
    output logic                res_src,
    output logic [TAG_W-1:0]    res_tag,
    output logic                res_err,

    output logic [CNT_W-1:0]    cnt0,
    output logic [CNT_W-1:0]    cnt1
);

    state_e             state_q, state_d;
    logic               last_q, last_d;
    alu_res_t           res_q, res_d;
    logic               src_q, src_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt0_q, cnt0_d;
    logic [CNT_W-1:0]   cnt1_q, cnt1_d;

    logic               slot_free;
    logic               grant_sel;
    logic               accept;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic [OP_W-1:0]    sel_op;
    logic [TAG_W-1:0]   sel_tag;
    alu_res_t           alu_res;

    // Arbitration: a tie goes to the requester that did not win last time.
    always_comb begin
        slot_free  = reset && ((state_q == ST_EMPTY) || res_ready);
        grant_sel  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        accept     = slot_free && (req0_valid || req1_valid);
        req0_ready = accept && !grant_sel;
        req1_ready = accept &&  grant_sel;

        sel_a   = grant_sel ? req1_opA : req0_opA;
        sel_b   = grant_sel ? req1_opB : req0_opB;
        sel_op  = grant_sel ? req1_op  : req0_op;
        sel_tag = grant_sel ? req1_tag : req0_tag;
    end

    alu_core u_alu_core (
        .op_a (sel_a),
        .op_b (sel_b),
        .op   (sel_op),
        .res  (alu_res)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (res_ready && !accept) state_d = ST_EMPTY;
        endcase
    end

    always_comb begin
        last_d = last_q;
        res_d  = res_q;
        src_d  = src_q;
        tag_d  = tag_q;
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept) begin
            last_d = grant_sel;
            res_d  = alu_res;
            src_d  = grant_sel;
            tag_d  = sel_tag;
            if (grant_sel) cnt1_d = cnt1_q + 16'd1;
            else           cnt0_d = cnt0_q + 16'd1;
        end
    end

    // last_q resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            last_q  <= 1'b1;
            res_q   <= '0;
            src_q   <= 1'b0;
            tag_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            last_q  <= last_d;
            res_q   <= res_d;
            src_q   <= src_d;
            tag_q   <= tag_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign res_valid = (state_q == ST_FULL);
    assign res_data  = res_q.data;
    assign res_ne    = res_q.ne;
    assign res_lt    = res_q.lt;
    assign res_ovf   = res_q.ovf;
    assign res_err   = res_q.err;
    assign res_src   = src_q;
    assign res_tag   = tag_q;
    assign cnt0      = cnt0_q;
    assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter: directed vector table, hand-written
// contention/backpressure/reset sequences, and randomized traffic vs a reference model.
module tb_alu_issue_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
    logic [4:0]  req0_op, req1_op;
    logic [3:0]  req0_tag, req1_tag;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_ne, res_lt, res_ovf, res_src, res_err;
    logic [3:0]  res_tag;
    logic [15:0] cnt0, cnt1;

    alu_issue_arbiter #(.TAG_W(4)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_opA(req0_opA), .req0_opB(req0_opB), .req0_op(req0_op), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_opA(req1_opA), .req1_opB(req1_opB), .req1_op(req1_op), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ne(res_ne), .res_lt(res_lt), .res_ovf(res_ovf),
        .res_src(res_src), .res_tag(res_tag), .res_err(res_err),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        ne, lt, ovf, err, src;
        logic [3:0]  tag;
    } exp_t;

    exp_t        m_res;
    bit          m_full;
    bit          m_last;
    logic [15:0] m_cnt0, m_cnt1;
    bit          exp_r0, exp_r1;

    typedef struct {
        bit          src;
        logic [31:0] a, b;
        logic [4:0]  op;
        logic [3:0]  tag;
        logic [31:0] data;
        bit          ne, lt, ovf, err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU from arithmetic on 64-bit signed values.
    function automatic exp_t alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        exp_t   r;
        longint sa, sb, s;
        r.data = '0; r.ne = 0; r.lt = 0; r.ovf = 0; r.err = 0; r.src = 0; r.tag = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            5'd0: begin
                s = sa + sb;
                r.data = 32'(s);
                r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            5'd1: begin
                s = sa - sb;
                r.data = 32'(s);
                r.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                r.ne   = (a != b);
                r.lt   = (sa < sb);
            end
            5'd2: r.data = a & b;
            5'd3: r.data = a | b;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_res.data = '0; m_res.ne = 0; m_res.lt = 0; m_res.ovf = 0;
        m_res.err = 0; m_res.src = 0; m_res.tag = '0;
        m_full = 0; m_last = 1; m_cnt0 = '0; m_cnt1 = '0;
    endtask

    task automatic model_ready();
        bit slot;
        slot   = !m_full || res_ready;
        exp_r0 = 0;
        exp_r1 = 0;
        if (slot) begin
            if (req0_valid && req1_valid) begin
                if (m_last) exp_r0 = 1; else exp_r1 = 1;
            end else if (req0_valid) exp_r0 = 1;
            else if (req1_valid)     exp_r1 = 1;
        end
    endtask

    task automatic check_outputs();
        check("res_valid", 32'(res_valid), 32'(m_full));
        check("res_data",  res_data,       m_res.data);
        check("res_ne",    32'(res_ne),    32'(m_res.ne));
        check("res_lt",    32'(res_lt),    32'(m_res.lt));
        check("res_ovf",   32'(res_ovf),   32'(m_res.ovf));
        check("res_err",   32'(res_err),   32'(m_res.err));
        check("res_src",   32'(res_src),   32'(m_res.src));
        check("res_tag",   32'(res_tag),   32'(m_res.tag));
        check("cnt0",      32'(cnt0),      32'(m_cnt0));
        check("cnt1",      32'(cnt1),      32'(m_cnt1));
    endtask

    // Called just after a falling edge with inputs driven; returns at the next falling edge.
    task automatic tick();
        #1;
        model_ready();
        check("req0_ready", 32'(req0_ready), 32'(exp_r0));
        check("req1_ready", 32'(req1_ready), 32'(exp_r1));
        check_outputs();
        @(posedge clock);
        if (exp_r0 || exp_r1) begin
            m_res     = exp_r0 ? alu_ref(req0_opA, req0_opB, req0_op)
                               : alu_ref(req1_opA, req1_opB, req1_op);
            m_res.src = exp_r1;
            m_res.tag = exp_r0 ? req0_tag : req1_tag;
            m_full    = 1;
            m_last    = exp_r1;
            if (exp_r0) m_cnt0 = m_cnt0 + 16'd1;
            else        m_cnt1 = m_cnt1 + 16'd1;
        end else if (m_full && res_ready) begin
            m_full = 0;
        end
        @(negedge clock);
    endtask

    task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] op, input logic [3:0] tag);
        if (idx == 0) begin
            req0_opA = a; req0_opB = b; req0_op = op; req0_tag = tag;
        end else begin
            req1_opA = a; req1_opB = b; req1_op = op; req1_tag = tag;
        end
    endtask

    // Asserts reset away from the clock edge; checks the immediate clear and that nothing is accepted.
    task automatic do_reset();
        reset      = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        #1;
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_data",  res_data,       32'd0);
        check("rst res_flags", 32'({res_ne, res_lt, res_ovf, res_err}), 32'd0);
        check("rst res_src",   32'(res_src),   32'd0);
        check("rst res_tag",   32'(res_tag),   32'd0);
        check("rst cnt0",      32'(cnt0),      32'd0);
        check("rst cnt1",      32'(cnt1),      32'd0);
        check("rst ready0",    32'(req0_ready), 32'd0);
        check("rst ready1",    32'(req1_ready), 32'd0);
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check("rst hold ready0", 32'(req0_ready), 32'd0);
        check("rst hold ready1", 32'(req1_ready), 32'd0);
        check("rst hold valid",  32'(res_valid),  32'd0);
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'(32'($urandom_range(0, 3)));
            3:       return 32'hFFFF_FFFF;
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        vecs[0] = '{0, 32'h7FFF_FFFF, 32'h0000_0001, 5'b00000, 4'd3,  32'h8000_0000, 0, 0, 1, 0};
        vecs[1] = '{1, 32'h0000_0005, 32'h0000_0009, 5'b00001, 4'd2,  32'hFFFF_FFFC, 1, 1, 0, 0};
        vecs[2] = '{0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00010, 4'd5,  32'h00F0_00F0, 0, 0, 0, 0};
        vecs[3] = '{1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00011, 4'd6,  32'hFFF0_FFF0, 0, 0, 0, 0};
        vecs[4] = '{0, 32'h8000_0000, 32'h0000_0001, 5'b00001, 4'd7,  32'h7FFF_FFFF, 1, 1, 1, 0};
        vecs[5] = '{1, 32'h0000_1234, 32'h0000_1234, 5'b00001, 4'd8,  32'h0000_0000, 0, 0, 0, 0};
        vecs[6] = '{0, 32'h0000_0005, 32'h0000_0009, 5'b00111, 4'd9,  32'h0000_0000, 0, 0, 0, 1};
        vecs[7] = '{1, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 4'd10, 32'h0000_0000, 0, 0, 0, 0};
        vecs[8] = '{0, 32'h8000_0000, 32'h8000_0000, 5'b00000, 4'd11, 32'h0000_0000, 0, 0, 1, 0};

        req0_valid = 0; req1_valid = 0; res_ready = 1;
        set_req(0, '0, '0, '0, '0);
        set_req(1, '0, '0, '0, '0);
        model_reset();

        @(negedge clock);
        do_reset();

        // Directed vectors, back to back with the consumer always ready.
        for (int i = 0; i < 9; i++) begin
            req0_valid = (vecs[i].src == 0);
            req1_valid = (vecs[i].src == 1);
            set_req(0, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
            set_req(1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tag);
            res_ready = 1;
            #1;
            check("vec ready_src",   32'(vecs[i].src ? req1_ready : req0_ready), 32'd1);
            check("vec ready_other", 32'(vecs[i].src ? req0_ready : req1_ready), 32'd0);
            tick();
            check("vec res_valid", 32'(res_valid), 32'd1);
            check("vec res_data",  res_data, vecs[i].data);
            check("vec res_flags", 32'({res_ne, res_lt, res_ovf, res_err}),
                  32'({vecs[i].ne, vecs[i].lt, vecs[i].ovf, vecs[i].err}));
            check("vec res_src",   32'(res_src), 32'(vecs[i].src));
            check("vec res_tag",   32'(res_tag), 32'(vecs[i].tag));
        end
        req0_valid = 0; req1_valid = 0;
        check("vec cnt0", 32'(cnt0), 32'd5);
        check("vec cnt1", 32'(cnt1), 32'd4);
        tick();
        tick();

        // Contention: both valid for four cycles, grants alternate from requester 0.
        do_reset();
        set_req(0, 32'd10, 32'd3, 5'b00000, 4'd1);
        set_req(1, 32'd10, 32'd3, 5'b00001, 4'd2);
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr ready0", 32'(req0_ready), 32'(k % 2 == 0));
            check("rr ready1", 32'(req1_ready), 32'(k % 2 == 1));
            tick();
        end
        check("rr cnt0", 32'(cnt0), 32'd2);
        check("rr cnt1", 32'(cnt1), 32'd2);

        // Backpressure: stalled consumer, both still requesting.
        res_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp ready0", 32'(req0_ready), 32'd0);
            check("bp ready1", 32'(req1_ready), 32'd0);
            check("bp res_src", 32'(res_src), 32'd1);
            check("bp res_data", res_data, 32'd7);
            tick();
        end
        res_ready = 1;
        #1;
        check("bp resume ready0", 32'(req0_ready), 32'd1);
        check("bp resume ready1", 32'(req1_ready), 32'd0);
        tick();

        // Reset while FULL, then the first tie goes to requester 0.
        check("pre-reset full", 32'(res_valid), 32'd1);
        do_reset();
        req0_valid = 1; req1_valid = 1; res_ready = 1;
        #1;
        check("post-rst ready0", 32'(req0_ready), 32'd1);
        check("post-rst ready1", 32'(req1_ready), 32'd0);
        tick();
        check("post-rst src", 32'(res_src), 32'd0);

        // FULL -> EMPTY when drained with no new request.
        req0_valid = 0; req1_valid = 0;
        tick();
        tick();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            res_ready  = ($urandom_range(0, 3) != 0);
            set_req(0, rand_word(), rand_word(), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            set_req(1, rand_word(), rand_word(), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            tick();
        end
        req0_valid = 0; req1_valid = 0; res_ready = 1;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
